tt_lockstep_checker: RTL and testbench

//  Parametrised lockstep comparator for NUM_DUT tile instances driven by common stimulus.
//  - Each tile presents one packed output word, {uo_out, uio_out, uio_oe}.
//  - Every cycle, each word is compared against a selectable reference instance under a bit mask.
//  - Accumulates saturating mismatch and cycle statistics and captures the first divergence.
//  - Sits beside the multi-design harness; replaces manual waveform diffing of ppwm/wrapper/sdr outputs.

---
 rtl/tt_lockstep_checker.sv | 165 ++++++++++++++++
 tb/tb_tt_lockstep_checker.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_lockstep_checker.sv
// ---------------------------------------------------------------------------
// tt_lockstep_checker
//
// Lockstep comparator for NUM_DUT tile instances that are driven by the same
// stimulus. Each cycle in RUN, every instance word is XORed against a latched
// reference instance under a bit mask. The block counts compared cycles and
// mismatching cycles, both saturating, and captures the first divergence.
//
// No valid/ready handshake: every input is sampled on every rising edge, and
// every output is a register or a direct OR of registers.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous reset, active-high, highest priority
//   ena           run request; low sends WARMUP/RUN back to IDLE (results kept)
//   clear         synchronous clear of statistics and capture, FSM -> IDLE
//   dut_out       packed instance words, instance i at [i*WIDTH +: WIDTH]
//   ref_sel       reference index, latched on IDLE -> WARMUP/RUN
//   mask          per-bit compare enable (1 = compared), sampled every cycle
//   state         FSM state: 0 IDLE, 1 WARMUP, 2 RUN, 3 HALT
//   mismatch_vec  per-instance mismatch of the last RUN cycle
//   mismatch_any  OR of mismatch_vec
//   cycle_cnt     RUN cycles compared, saturating
//   mismatch_cnt  RUN cycles with at least one mismatch, saturating
//   first_valid   sticky flag: first divergence captured
//   first_cycle   cycle_cnt value (pre-increment) at the first divergence
//   first_idx     lowest mismatching instance at the first divergence
//   first_diff    masked XOR against the reference at the first divergence
// ---------------------------------------------------------------------------
module tt_lockstep_checker #(
  parameter int NUM_DUT      = 3,
  parameter int WIDTH        = 24,
  parameter int CNT_W        = 16,
  parameter int WARMUP       = 4,
  parameter int STOP_ON_FAIL = 0,
  localparam int REF_W       = $clog2(NUM_DUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     clear,
  input  logic [NUM_DUT*WIDTH-1:0] dut_out,
  input  logic [REF_W-1:0]         ref_sel,
  input  logic [WIDTH-1:0]         mask,
  output logic [1:0]               state,
  output logic [NUM_DUT-1:0]       mismatch_vec,
  output logic                     mismatch_any,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         mismatch_cnt,
  output logic                     first_valid,
  output logic [CNT_W-1:0]         first_cycle,
  output logic [REF_W-1:0]         first_idx,
  output logic [WIDTH-1:0]         first_diff
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WARMUP = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  // Warmup counter counts 0 .. WARMUP-1; it is unused when WARMUP is 0.
  localparam int WC_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WC_W-1:0] WARM_LAST = WC_W'((WARMUP > 0) ? (WARMUP - 1) : 0);

  logic [WC_W-1:0]    warm_cnt;
  logic [REF_W-1:0]   ref_lat;

  logic [WIDTH-1:0]   word [NUM_DUT];
  logic [WIDTH-1:0]   diff [NUM_DUT];
  logic [WIDTH-1:0]   ref_word;
  logic [NUM_DUT-1:0] mism;
  logic               mism_any_now;
  logic [REF_W-1:0]   pick_idx;
  logic [WIDTH-1:0]   pick_diff;

  // Combinational compare of the current inputs against the latched reference.
  always_comb begin
    for (int i = 0; i < NUM_DUT; i++) begin
      word[i] = dut_out[i*WIDTH +: WIDTH];
    end
    ref_word = word[ref_lat];
    for (int i = 0; i < NUM_DUT; i++) begin
      diff[i] = (word[i] ^ ref_word) & mask;
      mism[i] = |diff[i];
    end
    mism_any_now = |mism;
    // Walk from the top down so the lowest mismatching index is the one kept.
    pick_idx  = '0;
    pick_diff = '0;
    for (int i = NUM_DUT - 1; i >= 0; i--) begin
      if (mism[i]) begin
        pick_idx  = REF_W'(i);
        pick_diff = diff[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state        <= S_IDLE;
      warm_cnt     <= '0;
      ref_lat      <= '0;
      mismatch_vec <= '0;
      cycle_cnt    <= '0;
      mismatch_cnt <= '0;
      first_valid  <= 1'b0;
      first_cycle  <= '0;
      first_idx    <= '0;
      first_diff   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          mismatch_vec <= '0;
          if (ena) begin
            // An out-of-range reference index falls back to instance 0.
            ref_lat  <= (32'(ref_sel) < NUM_DUT) ? ref_sel : '0;
            warm_cnt <= '0;
            state    <= (WARMUP == 0) ? S_RUN : S_WARMUP;
          end
        end
        S_WARMUP: begin
          mismatch_vec <= '0;
          if (!ena) begin
            state <= S_IDLE;
          end else if (warm_cnt == WARM_LAST) begin
            state <= S_RUN;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // The cycle is compared even when ena has just dropped; the FSM
          // leaves RUN on this same edge.
          mismatch_vec <= mism;
          if (cycle_cnt != {CNT_W{1'b1}}) begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
          if (mism_any_now) begin
            if (mismatch_cnt != {CNT_W{1'b1}}) begin
              mismatch_cnt <= mismatch_cnt + 1'b1;
            end
            if (!first_valid) begin
              first_valid <= 1'b1;
              first_cycle <= cycle_cnt;
              first_idx   <= pick_idx;
              first_diff  <= pick_diff;
            end
          end
          if ((STOP_ON_FAIL != 0) && mism_any_now) begin
            state <= S_HALT;
          end else if (!ena) begin
            state <= S_IDLE;
          end
        end
        default: begin
          // HALT: statistics frozen until clear or rst.
          mismatch_vec <= '0;
        end
      endcase
    end
  end

  assign mismatch_any = |mismatch_vec;

endmodule

// File: tb/tb_tt_lockstep_checker.sv
// ---------------------------------------------------------------------------
// tb_tt_lockstep_checker
//
// Three checker instances share one stimulus stream:
//   u0 : defaults (WARMUP=4, CNT_W=16, free running)
//   u1 : STOP_ON_FAIL=1
//   u2 : CNT_W=4, WARMUP=0
// A behavioural model of each instance is stepped on every rising edge and
// compared against every output on the following falling edge. Directed
// scenarios add hand-computed literal expectations on top.
// ---------------------------------------------------------------------------
module tb_tt_lockstep_checker;

  localparam int N = 3;
  localparam int W = 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ena, clear;
  logic [W-1:0]  word [N];
  logic [N*W-1:0] dut_out;
  logic [1:0]    ref_sel;
  logic [W-1:0]  mask;

  assign dut_out = {word[2], word[1], word[0]};

  // ---------------- DUT outputs ----------------
  logic [1:0]   st   [N];
  logic [2:0]   mvec [N];
  logic         many [N];
  logic [15:0]  cyc  [N];
  logic [15:0]  mcnt [N];
  logic         fv   [N];
  logic [15:0]  fc   [N];
  logic [1:0]   fi   [N];
  logic [W-1:0] fd   [N];
  logic [3:0]   cyc2_n, mcnt2_n, fc2_n;

  assign cyc[2]  = {12'd0, cyc2_n};
  assign mcnt[2] = {12'd0, mcnt2_n};
  assign fc[2]   = {12'd0, fc2_n};

  tt_lockstep_checker #(.NUM_DUT(3), .WIDTH(24), .CNT_W(16), .WARMUP(4), .STOP_ON_FAIL(0)) u0 (
    .clk(clk), .rst(rst), .ena(ena), .clear(clear), .dut_out(dut_out), .ref_sel(ref_sel),
    .mask(mask), .state(st[0]), .mismatch_vec(mvec[0]), .mismatch_any(many[0]),
    .cycle_cnt(cyc[0]), .mismatch_cnt(mcnt[0]), .first_valid(fv[0]), .first_cycle(fc[0]),
    .first_idx(fi[0]), .first_diff(fd[0]));

  tt_lockstep_checker #(.NUM_DUT(3), .WIDTH(24), .CNT_W(16), .WARMUP(4), .STOP_ON_FAIL(1)) u1 (
    .clk(clk), .rst(rst), .ena(ena), .clear(clear), .dut_out(dut_out), .ref_sel(ref_sel),
    .mask(mask), .state(st[1]), .mismatch_vec(mvec[1]), .mismatch_any(many[1]),
    .cycle_cnt(cyc[1]), .mismatch_cnt(mcnt[1]), .first_valid(fv[1]), .first_cycle(fc[1]),
    .first_idx(fi[1]), .first_diff(fd[1]));

  tt_lockstep_checker #(.NUM_DUT(3), .WIDTH(24), .CNT_W(4), .WARMUP(0), .STOP_ON_FAIL(0)) u2 (
    .clk(clk), .rst(rst), .ena(ena), .clear(clear), .dut_out(dut_out), .ref_sel(ref_sel),
    .mask(mask), .state(st[2]), .mismatch_vec(mvec[2]), .mismatch_any(many[2]),
    .cycle_cnt(cyc2_n), .mismatch_cnt(mcnt2_n), .first_valid(fv[2]), .first_cycle(fc2_n),
    .first_idx(fi[2]), .first_diff(fd[2]));

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per-instance configuration.
  int p_warm [N] = '{4, 4, 0};
  int p_stop [N] = '{0, 1, 0};
  int p_max  [N] = '{65535, 65535, 15};

  // mode: 0 idle, 1 warming up, 2 comparing, 3 halted
  int           m_st [N], m_left [N], m_ref [N], m_vec [N];
  int           m_cyc [N], m_mc [N], m_fv [N], m_fc [N], m_fi [N];
  logic [W-1:0] m_fd [N];

  task automatic model_reset(input int k);
    m_st[k] = 0; m_left[k] = 0; m_ref[k] = 0; m_vec[k] = 0;
    m_cyc[k] = 0; m_mc[k] = 0; m_fv[k] = 0; m_fc[k] = 0; m_fi[k] = 0; m_fd[k] = '0;
  endtask

  task automatic model_step();
    for (int k = 0; k < N; k++) begin
      if (rst || clear) begin
        model_reset(k);
      end else if (m_st[k] == 0) begin
        m_vec[k] = 0;
        if (ena) begin
          m_ref[k] = (int'(ref_sel) < N) ? int'(ref_sel) : 0;
          if (p_warm[k] == 0) m_st[k] = 2;
          else begin
            m_st[k]   = 1;
            m_left[k] = p_warm[k];
          end
        end
      end else if (m_st[k] == 1) begin
        m_vec[k] = 0;
        if (!ena) m_st[k] = 0;
        else begin
          m_left[k] = m_left[k] - 1;
          if (m_left[k] == 0) m_st[k] = 2;
        end
      end else if (m_st[k] == 2) begin
        int           vec;
        int           first;
        logic [W-1:0] d, first_d;
        vec = 0; first = -1; first_d = '0;
        for (int j = 0; j < N; j++) begin
          d = (word[j] ^ word[m_ref[k]]) & mask;
          if (d != '0) begin
            vec = vec | (1 << j);
            if (first < 0) begin
              first   = j;
              first_d = d;
            end
          end
        end
        m_vec[k] = vec;
        if (vec != 0 && m_fv[k] == 0) begin
          m_fv[k] = 1; m_fc[k] = m_cyc[k]; m_fi[k] = first; m_fd[k] = first_d;
        end
        if (m_cyc[k] < p_max[k]) m_cyc[k] = m_cyc[k] + 1;
        if (vec != 0 && m_mc[k] < p_max[k]) m_mc[k] = m_mc[k] + 1;
        if (p_stop[k] != 0 && vec != 0) m_st[k] = 3;
        else if (!ena) m_st[k] = 0;
      end else begin
        m_vec[k] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < N; k++) begin
      check($sformatf("model_state[%0d]", k), 32'(st[k]), m_st[k]);
      check($sformatf("model_vec[%0d]", k), 32'(mvec[k]), m_vec[k]);
      check($sformatf("model_any[%0d]", k), 32'(many[k]), (m_vec[k] != 0) ? 1 : 0);
      check($sformatf("model_cycle_cnt[%0d]", k), 32'(cyc[k]), m_cyc[k]);
      check($sformatf("model_mismatch_cnt[%0d]", k), 32'(mcnt[k]), m_mc[k]);
      check($sformatf("model_first_valid[%0d]", k), 32'(fv[k]), m_fv[k]);
      check($sformatf("model_first_cycle[%0d]", k), 32'(fc[k]), m_fc[k]);
      check($sformatf("model_first_idx[%0d]", k), 32'(fi[k]), m_fi[k]);
      check($sformatf("model_first_diff[%0d]", k), 32'(fd[k]), 32'(m_fd[k]));
    end
  endtask

  initial for (int k = 0; k < N; k++) model_reset(k);

  // Model steps on the active edge, compare runs on the opposite edge.
  always begin
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (chk_on) compare_all();
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_run(input int k);
    for (int i = 0; i < 30; i++) begin
      if (st[k] == 2'd2) break;
      tick(1);
    end
    check($sformatf("wait_run[%0d]", k), 32'(st[k]), 32'd2);
  endtask

  task automatic do_clear();
    ena = 1'b0; clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic run_pair(input logic [1:0] rs, input logic [W-1:0] f0, input logic [W-1:0] f1,
                          input logic [W-1:0] f2, input logic [31:0] e_vec,
                          input logic [31:0] e_idx, input logic [31:0] e_diff);
    do_clear();
    ref_sel = rs;
    ena = 1'b1;
    wait_run(0);
    tick(2);
    word[0] ^= f0; word[1] ^= f1; word[2] ^= f2;
    tick(1);
    check("pair_vec", 32'(mvec[0]), e_vec);
    check("pair_any", 32'(many[0]), 32'd1);
    word[0] ^= f0; word[1] ^= f1; word[2] ^= f2;
    tick(1);
    check("pair_idx", 32'(fi[0]), e_idx);
    check("pair_diff", 32'(fd[0]), e_diff);
    check("pair_mcnt", 32'(mcnt[0]), 32'd1);
    ena = 1'b0;
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; ena = 1'b0; clear = 1'b0; ref_sel = 2'd0; mask = '1;
    for (int i = 0; i < N; i++) word[i] = 24'hA5A5A5;
    tick(1);
    chk_on = 1'b1;
    tick(1);
    rst = 1'b0;
    check("reset_state", 32'(st[0]), 32'd0);
    check("reset_cycle_cnt", 32'(cyc[0]), 32'd0);

    // 1: identical words, ena high for 20 sampled edges.
    ena = 1'b1;
    tick(1);
    check("t1_u2_direct_run", 32'(st[2]), 32'd2);
    check("t1_warmup_e1", 32'(st[0]), 32'd1);
    tick(3);
    check("t1_warmup_e4", 32'(st[0]), 32'd1);
    tick(1);
    check("t1_run_e5", 32'(st[0]), 32'd2);
    tick(15);
    ena = 1'b0;
    tick(1);
    check("t1_cycle_cnt", 32'(cyc[0]), 32'd16);
    check("t1_mismatch_cnt", 32'(mcnt[0]), 32'd0);
    check("t1_first_valid", 32'(fv[0]), 32'd0);
    check("t1_idle", 32'(st[0]), 32'd0);
    check("t1_u2_saturated", 32'(cyc[2]), 32'd15);

    // 2: instance 2 bit 3 flipped on RUN cycle 7 only.
    do_clear();
    ref_sel = 2'd0;
    ena = 1'b1;
    wait_run(0);
    tick(7);
    word[2] ^= 24'h000008;
    tick(1);
    check("t2_vec", 32'(mvec[0]), 32'b100);
    word[2] ^= 24'h000008;
    tick(1);
    check("t2_vec_clear", 32'(mvec[0]), 32'd0);
    tick(3);
    check("t2_first_idx", 32'(fi[0]), 32'd2);
    check("t2_first_cycle", 32'(fc[0]), 32'd7);
    check("t2_first_diff", 32'(fd[0]), 32'h000008);
    check("t2_mismatch_cnt", 32'(mcnt[0]), 32'd1);
    check("t2_first_valid", 32'(fv[0]), 32'd1);
    ena = 1'b0;
    tick(1);

    // 3: multi-instance mismatch, in-range and out-of-range reference.
    run_pair(2'd0, 24'h0, 24'h010000, 24'h000100, 32'b110, 32'd1, 32'h010000);
    run_pair(2'd3, 24'h0, 24'h010000, 24'h000100, 32'b110, 32'd1, 32'h010000);
    run_pair(2'd2, 24'h0, 24'h0, 24'h00F000, 32'b011, 32'd0, 32'h00F000);

    // 4: STOP_ON_FAIL instance halts at cycle 2 and ignores ena.
    do_clear();
    ref_sel = 2'd0;
    ena = 1'b1;
    wait_run(1);
    tick(2);
    word[1] ^= 24'h000001;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      ena = (i % 2) != 0;
      tick(1);
    end
    check("t4_halt", 32'(st[1]), 32'd3);
    check("t4_cycle_cnt", 32'(cyc[1]), 32'd3);
    check("t4_mismatch_cnt", 32'(mcnt[1]), 32'd1);
    check("t4_first_cycle", 32'(fc[1]), 32'd2);
    check("t4_first_idx", 32'(fi[1]), 32'd1);
    do_clear();
    check("t4_clr_state", 32'(st[1]), 32'd0);
    check("t4_clr_cycle", 32'(cyc[1]), 32'd0);
    check("t4_clr_mcnt", 32'(mcnt[1]), 32'd0);
    check("t4_clr_fv", 32'(fv[1]), 32'd0);
    check("t4_clr_fd", 32'(fd[1]), 32'd0);
    word[1] ^= 24'h000001;

    // 5: 4-bit counters saturate under constant mismatch; mask=0 hides it.
    word[1] ^= 24'h800000;
    ena = 1'b1;
    tick(21);
    check("t5_sat_cycle", 32'(cyc[2]), 32'd15);
    check("t5_sat_mcnt", 32'(mcnt[2]), 32'd15);
    check("t5_first_cycle", 32'(fc[2]), 32'd0);
    ena = 1'b0; clear = 1'b1; mask = '0;
    tick(1);
    clear = 1'b0;
    ena = 1'b1;
    tick(10);
    check("t5_mask0_mcnt", 32'(mcnt[2]), 32'd0);
    check("t5_mask0_cycle", 32'(cyc[2]), 32'd9);
    check("t5_mask0_fv", 32'(fv[2]), 32'd0);
    ena = 1'b0; mask = '1;
    word[1] ^= 24'h800000;
    tick(1);

    // 6: rst mid-RUN while clear and ena are also high.
    do_clear();
    ena = 1'b1;
    tick(8);
    rst = 1'b1; clear = 1'b1;
    tick(1);
    check("t6_state", 32'(st[0]), 32'd0);
    check("t6_cycle", 32'(cyc[0]), 32'd0);
    check("t6_u2_cycle", 32'(cyc[2]), 32'd0);
    rst = 1'b0; clear = 1'b0;
    tick(1);
    check("t6_warmup_restart", 32'(st[0]), 32'd1);
    ena = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
